hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Producer side of the program-counter register interface: generates the 16-bit next-PC value and the active-high stall that the PC register consumes. Also drives the IF/ID and ID/EX pipeline-control strobes.
- Sits between the decode/execute stages and the PC register of the pipelined 16-bit CPU.
- Resolves three events:
  - load-use data hazards;
  - taken-branch redirects, with a multi-cycle wrong-path flush;
  - multi-cycle data-memory waits.
- Also handles a HALT instruction.

Parameters:
ADDR_W, 16, PC/address width
REG_W, 4, register-specifier width (16 architectural registers, r0 hard-wired zero)
FLUSH_CYCLES, 2, cycles of IF/ID flush after redirect (1 = redirect cycle only; registered IMEM requires 2); legal range 1..15

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
pc_cur  in  ADDR_W  current PC register output
branch_taken  in  1  EX stage resolved a taken branch/jump this cycle
branch_target  in  ADDR_W  EX-stage redirect address
id_rs  in  REG_W  ID-stage source register 1
id_rt  in  REG_W  ID-stage source register 2
id_uses_rs  in  1  ID instruction reads id_rs
id_uses_rt  in  1  ID instruction reads id_rt
id_halt  in  1  ID instruction is HALT
ex_memread  in  1  EX instruction is a load
ex_rd  in  REG_W  EX instruction destination
mem_busy  in  1  data memory not ready; whole pipeline must freeze
pc_next  out  ADDR_W  value presented to PC register input
pc_stall  out  1  1 = PC register holds
ifid_stall  out  1  1 = IF/ID register holds
ifid_flush  out  1  1 = IF/ID loads a NOP
idex_bubble  out  1  1 = ID/EX loads a NOP
stall_cnt  out  16  performance counter (see Optional Feature)
flush_cnt  out  16  performance counter (see Optional Feature)

Behaviour:
- One clock domain. Reset is asynchronous and active-high. rst → state RUN, flush counter 0, perf counters 0.
- All control outputs are combinational from registered state plus current inputs, giving zero-cycle latency to the PC register. In reset, outputs evaluate as state RUN.
- pc_next = branch_taken ? branch_target : pc_cur + 1, modulo 2^ADDR_W (0xFFFF → 0x0000). Combinational in every state; pc_stall gates its use.
- load_use = ex_memread & (ex_rd != 0) & ((id_uses_rs & id_rs == ex_rd) | (id_uses_rt & id_rt == ex_rd)).
- Per-cycle priority: mem_busy > branch_taken > id_halt > load_use.
- States: RUN, FLUSH, HALTED.
- mem_busy=1, any state except HALTED:
  - outputs: pc_stall=1, ifid_stall=1, ifid_flush=0, idex_bubble=0;
  - state and flush counter held;
  - branch_taken ignored, because EX is frozen and upstream holds it.
- RUN, branch_taken=1:
  - outputs: pc_stall=0, ifid_flush=1, idex_bubble=1;
  - if FLUSH_CYCLES>1, load counter with FLUSH_CYCLES-1 and go to FLUSH; otherwise stay in RUN.
- RUN, id_halt=1 (no branch):
  - outputs: pc_stall=1, ifid_stall=1, idex_bubble=0;
  - go to HALTED. The HALT itself proceeds down the pipeline on the next cycle.
- RUN, load_use=1:
  - outputs: pc_stall=1, ifid_stall=1, idex_bubble=1;
  - stay in RUN. Exactly one stall cycle, because the load advances to MEM.
- RUN, no event: all control outputs 0.
- FLUSH:
  - outputs: pc_stall=0, ifid_flush=1, idex_bubble=1;
  - load_use, id_halt and branch_taken are ignored (wrong-path/bubble);
  - counter decrements; at counter==1, next state is RUN.
- HALTED:
  - outputs: pc_stall=1, ifid_flush=1, idex_bubble=1;
  - stays in HALTED until rst, regardless of mem_busy.
- Reset mid-FLUSH or in HALTED → RUN immediately, counter cleared.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined:
  - stall_cnt increments on every cycle with pc_stall=1 and state≠HALTED;
  - flush_cnt increments on every cycle with ifid_flush=1 and state≠HALTED;
  - both are 16-bit, saturate at 0xFFFF and clear on rst.
- Undefined: both ports remain present and are tied to 0; no counter flops are inferred.

Decomposition:
- Shared package/header holds:
  - state encodings (RUN=2'd0, FLUSH=2'd1, HALTED=2'd2);
  - ADDR_W and REG_W defaults;
  - the NOP encoding used by the pipeline registers.
- One sub-module: hazard_sat_cnt (16-bit saturating counter with enable and async rst), instantiated twice under HAZARD_PERF_CNT_EN.

Test Plan:
- rst pulse mid-cycle with pc_cur=0x0010: outputs low asynchronously; pc_next=0x0011, pc_stall=0 → state RUN, counters 0.
- Load-use: ex_memread=1, ex_rd=3, id_rs=3, id_uses_rs=1 → one cycle pc_stall=ifid_stall=idex_bubble=1, then 0. Repeat with ex_rd=0 → no stall.
- Branch with FLUSH_CYCLES=2: branch_taken=1, branch_target=0x0040 → pc_next=0x0040, pc_stall=0, ifid_flush=1 for 2 consecutive cycles, idex_bubble=1 for 2 cycles. Concurrent load_use in the second cycle → ignored.
- mem_busy high 3 cycles coinciding with branch_taken → pc_stall=1 for 3 cycles, no flush; redirect to target on the 4th cycle. mem_busy raised mid-FLUSH → counter frozen, flush resumes afterwards.
- Wrap: pc_cur=0xFFFF, no events → pc_next=0x0000.
- id_halt=1 → HALTED; pc_stall stays 1 for 100 cycles despite branch_taken; rst → RUN. With HAZARD_PERF_CNT_EN, 70000 forced stall cycles → stall_cnt=0xFFFF.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the hazard controller: state encodings, default
// widths and the pipeline NOP encoding.
package hazard_ctrl_pkg;

   localparam int ADDR_W_DEF = 16;
   localparam int REG_W_DEF  = 4;

   // Instruction word the IF/ID and ID/EX registers load on flush/bubble
   localparam logic [15:0] NOP_INSTR = 16'h0000;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_FLUSH  = 2'd1,
      ST_HALTED = 2'd2
   } hz_state_t;

endpackage

// File: rtl/hazard_sat_cnt.sv
// Saturating up-counter with enable and asynchronous active-high reset.
// Only compiled when HAZARD_PERF_CNT_EN is defined, since it is the sole
// user of this module.
`ifdef HAZARD_PERF_CNT_EN
module hazard_sat_cnt #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   output logic [CNT_W-1:0] cnt
);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // Count enabled cycles, sticking at all-ones
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (en)
         cnt <= sat_inc(cnt);
   end

endmodule
`endif

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 16-bit pipelined CPU. Produces next-PC and
// PC stall, plus IF/ID stall/flush and ID/EX bubble strobes, resolving
// memory waits, taken-branch redirects (with multi-cycle wrong-path
// flush), HALT and load-use hazards.
// Optional: define HAZARD_PERF_CNT_EN to build the stall/flush
// performance counters; otherwise those ports are tied to zero.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int ADDR_W       = ADDR_W_DEF,
   parameter int REG_W        = REG_W_DEF,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc_cur,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] branch_target,
   input  logic [REG_W-1:0]  id_rs,
   input  logic [REG_W-1:0]  id_rt,
   input  logic              id_uses_rs,
   input  logic              id_uses_rt,
   input  logic              id_halt,
   input  logic              ex_memread,
   input  logic [REG_W-1:0]  ex_rd,
   input  logic              mem_busy,
   output logic [ADDR_W-1:0] pc_next,
   output logic              pc_stall,
   output logic              ifid_stall,
   output logic              ifid_flush,
   output logic              idex_bubble,
   output logic [15:0]       stall_cnt,
   output logic [15:0]       flush_cnt
);

   hz_state_t  state_q, state_d;
   logic [3:0] fcnt_q, fcnt_d;
   logic       load_use;

   // Load in EX writing a register the ID instruction reads (r0 never hazards)
   always_comb begin
      load_use = ex_memread && (ex_rd != '0) &&
                 ((id_uses_rs && (id_rs == ex_rd)) ||
                  (id_uses_rt && (id_rt == ex_rd)));
   end

   // Next PC is always computed; pc_stall decides whether the PC takes it
   always_comb begin
      pc_next = branch_taken ? branch_target : pc_cur + ADDR_W'(1);
   end

   // Control strobes and next state, priority mem_busy > branch > halt > load-use
   always_comb begin
      pc_stall    = 1'b0;
      ifid_stall  = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      state_d     = state_q;
      fcnt_d      = fcnt_q;
      case (state_q)
         ST_HALTED: begin
            pc_stall    = 1'b1;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
         end
         ST_FLUSH: begin
            if (mem_busy) begin
               pc_stall   = 1'b1;
               ifid_stall = 1'b1;
            end else begin
               ifid_flush  = 1'b1;
               idex_bubble = 1'b1;
               fcnt_d      = fcnt_q - 4'd1;
               if (fcnt_q == 4'd1)
                  state_d = ST_RUN;
            end
         end
         default: begin
            if (mem_busy) begin
               // EX is frozen, so a pending branch is re-presented later
               pc_stall   = 1'b1;
               ifid_stall = 1'b1;
            end else if (branch_taken) begin
               ifid_flush  = 1'b1;
               idex_bubble = 1'b1;
               if (FLUSH_CYCLES > 1) begin
                  fcnt_d  = 4'(FLUSH_CYCLES - 1);
                  state_d = ST_FLUSH;
               end
            end else if (id_halt) begin
               // HALT itself still moves into EX next cycle
               pc_stall   = 1'b1;
               ifid_stall = 1'b1;
               state_d    = ST_HALTED;
            end else if (load_use) begin
               pc_stall    = 1'b1;
               ifid_stall  = 1'b1;
               idex_bubble = 1'b1;
            end
         end
      endcase
   end

   // State and flush-counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_RUN;
         fcnt_q  <= 4'd0;
      end else begin
         state_q <= state_d;
         fcnt_q  <= fcnt_d;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic stall_en, flush_en;

   // HALTED cycles are idle, not hazards, so they are not counted
   always_comb begin
      stall_en = pc_stall   && (state_q != ST_HALTED);
      flush_en = ifid_flush && (state_q != ST_HALTED);
   end

   hazard_sat_cnt #(.CNT_W(16)) u_stall_cnt (
      .clk (clk),
      .rst (rst),
      .en  (stall_en),
      .cnt (stall_cnt)
   );

   hazard_sat_cnt #(.CNT_W(16)) u_flush_cnt (
      .clk (clk),
      .rst (rst),
      .en  (flush_en),
      .cnt (flush_cnt)
   );
`else
   assign stall_cnt = 16'd0;
   assign flush_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl (FLUSH_CYCLES = 2). Each stimulus
// row pushes its expected outputs to a scoreboard; the row's task pops
// and compares at the following falling edge.
module tb_hazard_ctrl;

`ifdef HAZARD_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic        clk, rst;
   logic [15:0] pc_cur, branch_target;
   logic        branch_taken;
   logic [3:0]  id_rs, id_rt, ex_rd;
   logic        id_uses_rs, id_uses_rt, id_halt, ex_memread, mem_busy;
   logic [15:0] pc_next;
   logic        pc_stall, ifid_stall, ifid_flush, idex_bubble;
   logic [15:0] stall_cnt, flush_cnt;

   int errors = 0;
   int checks = 0;

   // pc, bt, tgt, memread, rd, rs, uses_rs, rt, uses_rt, halt, busy,
   // expected pc_next, expected {pc_stall, ifid_stall, ifid_flush, idex_bubble}
   typedef struct packed {
      logic [15:0] pc;
      logic        bt;
      logic [15:0] tgt;
      logic        mr;
      logic [3:0]  rd;
      logic [3:0]  rs;
      logic        urs;
      logic [3:0]  rt;
      logic        urt;
      logic        halt;
      logic        mb;
      logic [15:0] epc;
      logic [3:0]  ectl;
   } row_t;

   logic [19:0] sb[$];

   hazard_ctrl #(.ADDR_W(16), .REG_W(4), .FLUSH_CYCLES(2)) dut (
      .clk           (clk),
      .rst           (rst),
      .pc_cur        (pc_cur),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .id_rs         (id_rs),
      .id_rt         (id_rt),
      .id_uses_rs    (id_uses_rs),
      .id_uses_rt    (id_uses_rt),
      .id_halt       (id_halt),
      .ex_memread    (ex_memread),
      .ex_rd         (ex_rd),
      .mem_busy      (mem_busy),
      .pc_next       (pc_next),
      .pc_stall      (pc_stall),
      .ifid_stall    (ifid_stall),
      .ifid_flush    (ifid_flush),
      .idex_bubble   (idex_bubble),
      .stall_cnt     (stall_cnt),
      .flush_cnt     (flush_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic row_t idle(input logic [15:0] pc);
      row_t r;
      r      = '0;
      r.pc   = pc;
      r.epc  = pc + 16'd1;
      r.ectl = 4'b0000;
      return r;
   endfunction

   task automatic apply(input row_t r);
      pc_cur        = r.pc;
      branch_taken  = r.bt;
      branch_target = r.tgt;
      ex_memread    = r.mr;
      ex_rd         = r.rd;
      id_rs         = r.rs;
      id_uses_rs    = r.urs;
      id_rt         = r.rt;
      id_uses_rt    = r.urt;
      id_halt       = r.halt;
      mem_busy      = r.mb;
      sb.push_back({r.epc, r.ectl});
   endtask

   task automatic test_reset();
      logic [19:0] got, exp;
      apply(idle(16'h0010));
      #2 rst = 1'b1;
      #1;
      got = {pc_next, pc_stall, ifid_stall, ifid_flush, idex_bubble};
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL reset_outputs: got %h want %h", got, exp);
      end
      checks++;
      if ({stall_cnt, flush_cnt} !== 32'd0) begin
         errors++;
         $display("FAIL reset_counters: got %h/%h want 0/0", stall_cnt, flush_cnt);
      end
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_load_use();
      row_t rows[7];
      logic [19:0] got, exp;
      rows = '{
         '{16'h0020, 1'b0, 16'h0000, 1'b1, 4'd3, 4'd3, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0021, 4'b1101},
         '{16'h0020, 1'b0, 16'h0000, 1'b0, 4'd3, 4'd3, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0021, 4'b0000},
         '{16'h0021, 1'b0, 16'h0000, 1'b1, 4'd0, 4'd0, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 16'h0022, 4'b0000},
         '{16'h0022, 1'b0, 16'h0000, 1'b1, 4'd5, 4'd1, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0, 16'h0023, 4'b1101},
         '{16'h0022, 1'b0, 16'h0000, 1'b0, 4'd5, 4'd1, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0, 16'h0023, 4'b0000},
         '{16'h0023, 1'b0, 16'h0000, 1'b1, 4'd7, 4'd7, 1'b0, 4'd7, 1'b0, 1'b0, 1'b0, 16'h0024, 4'b0000},
         '{16'h0024, 1'b0, 16'h0000, 1'b0, 4'd7, 4'd7, 1'b1, 4'd7, 1'b1, 1'b0, 1'b0, 16'h0025, 4'b0000}
      };
      for (int i = 0; i < 7; i++) begin
         @(posedge clk); #1;
         apply(rows[i]);
         @(negedge clk);
         got = {pc_next, pc_stall, ifid_stall, ifid_flush, idex_bubble};
         exp = sb.pop_front();
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL load_use[%0d]: got %h want %h", i, got, exp);
         end
      end
   endtask

   task automatic test_branch();
      row_t rows[6];
      logic [19:0] got, exp;
      rows = '{
         '{16'h0030, 1'b1, 16'h0040, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0040, 4'b0011},
         '{16'h0040, 1'b0, 16'h0000, 1'b1, 4'd3, 4'd3, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0041, 4'b0011},
         '{16'h0041, 1'b0, 16'h0000, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0042, 4'b0000},
         '{16'h0042, 1'b1, 16'h0060, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 16'h0060, 4'b0011},
         '{16'h0060, 1'b1, 16'h0070, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 16'h0070, 4'b0011},
         '{16'h0061, 1'b0, 16'h0000, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0062, 4'b0000}
      };
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         apply(rows[i]);
         @(negedge clk);
         got = {pc_next, pc_stall, ifid_stall, ifid_flush, idex_bubble};
         exp = sb.pop_front();
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL branch[%0d]: got %h want %h", i, got, exp);
         end
      end
   endtask

   task automatic test_mem_busy();
      row_t rows[10];
      logic [19:0] got, exp;
      rows = '{
         '{16'h0050, 1'b1, 16'h0080, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 16'h0080, 4'b1100},
         '{16'h0050, 1'b1, 16'h0080, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 16'h0080, 4'b1100},
         '{16'h0050, 1'b1, 16'h0080, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 16'h0080, 4'b1100},
         '{16'h0050, 1'b1, 16'h0080, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0080, 4'b0011},
         '{16'h0080, 1'b0, 16'h0000, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 16'h0081, 4'b1100},
         '{16'h0080, 1'b0, 16'h0000, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 16'h0081, 4'b1100},
         '{16'h0080, 1'b0, 16'h0000, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0081, 4'b0011},
         '{16'h0081, 1'b0, 16'h0000, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0082, 4'b0000},
         '{16'h0082, 1'b0, 16'h0000, 1'b1, 4'd3, 4'd3, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1, 16'h0083, 4'b1100},
         '{16'h0082, 1'b0, 16'h0000, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0083, 4'b0000}
      };
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         apply(rows[i]);
         @(negedge clk);
         got = {pc_next, pc_stall, ifid_stall, ifid_flush, idex_bubble};
         exp = sb.pop_front();
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL mem_busy[%0d]: got %h want %h", i, got, exp);
         end
      end
   endtask

   task automatic test_wrap();
      row_t rows[2];
      logic [19:0] got, exp;
      rows = '{
         '{16'hFFFF, 1'b0, 16'h0000, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 4'b0000},
         '{16'hFFFF, 1'b0, 16'h0000, 1'b1, 4'd2, 4'd2, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 4'b1101}
      };
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         apply(rows[i]);
         @(negedge clk);
         got = {pc_next, pc_stall, ifid_stall, ifid_flush, idex_bubble};
         exp = sb.pop_front();
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL wrap[%0d]: got %h want %h", i, got, exp);
         end
      end
   endtask

   task automatic test_halt();
      row_t r;
      logic [19:0] got, exp;
      // cycle 0 is the HALT in RUN, cycles 1..100 sit in HALTED with branches and busy toggling
      for (int i = 0; i <= 100; i++) begin
         r = idle(16'h0090);
         if (i == 0) begin
            r.halt = 1'b1;
            r.ectl = 4'b1100;
         end else begin
            r.bt   = 1'b1;
            r.tgt  = 16'h0055;
            r.mb   = i[0];
            r.epc  = 16'h0055;
            r.ectl = 4'b1011;
         end
         @(posedge clk); #1;
         apply(r);
         @(negedge clk);
         got = {pc_next, pc_stall, ifid_stall, ifid_flush, idex_bubble};
         exp = sb.pop_front();
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL halt[%0d]: got %h want %h", i, got, exp);
         end
      end
      // asynchronous reset mid-cycle must release HALTED at once
      @(posedge clk); #3;
      apply(idle(16'h0090));
      rst = 1'b1;
      #1;
      got = {pc_next, pc_stall, ifid_stall, ifid_flush, idex_bubble};
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL halt_async_rst: got %h want %h", got, exp);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      apply(idle(16'h0091));
      @(negedge clk);
      got = {pc_next, pc_stall, ifid_stall, ifid_flush, idex_bubble};
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL halt_after_rst: got %h want %h", got, exp);
      end
   endtask

   task automatic test_reset_mid_flush();
      row_t r;
      logic [19:0] got, exp;
      r      = idle(16'h00A0);
      r.bt   = 1'b1;
      r.tgt  = 16'h00C0;
      r.epc  = 16'h00C0;
      r.ectl = 4'b0011;
      @(posedge clk); #1;
      apply(r);
      @(negedge clk);
      got = {pc_next, pc_stall, ifid_stall, ifid_flush, idex_bubble};
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL flush_rst_redirect: got %h want %h", got, exp);
      end
      // now in FLUSH; reset partway through the cycle returns to RUN outputs
      @(posedge clk); #3;
      apply(idle(16'h00C0));
      rst = 1'b1;
      #1;
      got = {pc_next, pc_stall, ifid_stall, ifid_flush, idex_bubble};
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL flush_async_rst: got %h want %h", got, exp);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      apply(idle(16'h00C1));
      @(negedge clk);
      got = {pc_next, pc_stall, ifid_stall, ifid_flush, idex_bubble};
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL flush_after_rst: got %h want %h", got, exp);
      end
   endtask

   task automatic test_perf_cnt();
      row_t r;
      logic [19:0] got, exp;
      logic [15:0] es, ef;
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({stall_cnt, flush_cnt} !== 32'd0) begin
         errors++;
         $display("FAIL perf_rst: got %h/%h want 0/0", stall_cnt, flush_cnt);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      // 0-2 busy, 3 idle, 4 branch, 5 flush, 6 idle, 7 halt, 8-12 halted
      for (int i = 0; i < 13; i++) begin
         if (i < 3) begin
            r = idle(16'h0010); r.mb = 1'b1; r.ectl = 4'b1100;
         end else if (i == 3) begin
            r = idle(16'h0010);
         end else if (i == 4) begin
            r = idle(16'h0010); r.bt = 1'b1; r.tgt = 16'h0040;
            r.epc = 16'h0040; r.ectl = 4'b0011;
         end else if (i == 5) begin
            r = idle(16'h0040); r.ectl = 4'b0011;
         end else if (i == 6) begin
            r = idle(16'h0041);
         end else if (i == 7) begin
            r = idle(16'h0042); r.halt = 1'b1; r.ectl = 4'b1100;
         end else begin
            r = idle(16'h0042); r.ectl = 4'b1011;
         end
         @(posedge clk); #1;
         apply(r);
         @(negedge clk);
         got = {pc_next, pc_stall, ifid_stall, ifid_flush, idex_bubble};
         exp = sb.pop_front();
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL perf_seq[%0d]: got %h want %h", i, got, exp);
         end
         if (i == 3 || i == 6 || i == 12) begin
            es = PERF ? ((i == 12) ? 16'd4 : 16'd3) : 16'd0;
            ef = PERF ? ((i == 3) ? 16'd0 : 16'd2) : 16'd0;
            checks++;
            if ({stall_cnt, flush_cnt} !== {es, ef}) begin
               errors++;
               $display("FAIL perf_cnt[%0d]: got stall=%0d flush=%0d want stall=%0d flush=%0d",
                        i, stall_cnt, flush_cnt, es, ef);
            end
         end
      end
`ifdef HAZARD_PERF_CNT_EN
      @(posedge clk); #2;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      r = idle(16'h0010); r.mb = 1'b1; r.ectl = 4'b1100;
      apply(r);
      repeat (70000) @(posedge clk);
      @(negedge clk);
      got = {pc_next, pc_stall, ifid_stall, ifid_flush, idex_bubble};
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL perf_long_outputs: got %h want %h", got, exp);
      end
      checks++;
      if ({stall_cnt, flush_cnt} !== {16'hFFFF, 16'h0000}) begin
         errors++;
         $display("FAIL perf_saturate: got stall=%h flush=%h want stall=ffff flush=0000",
                  stall_cnt, flush_cnt);
      end
`endif
   endtask

   initial begin
      rst = 1'b0;
      apply(idle(16'h0010));
      void'(sb.pop_front());
      test_reset();
      test_load_use();
      test_branch();
      test_mem_busy();
      test_wrap();
      test_halt();
      test_reset_mid_flush();
      test_perf_cnt();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
